// File: rtl/bcp_cmd_sequencer.sv
// Command front-end for the BCP core: packs stream commands into the core's
// command registers, runs the clear/status handshake and queues status responses.
module bcp_cmd_sequencer #(
  parameter int FORMULA_MAX_VARIABLE  = 20,
  parameter int VARIABLE_ENCODING_LEN = $clog2(FORMULA_MAX_VARIABLE + 1),
  parameter int MAX_CLAUSE            = 91,
  parameter int CLAUSE_ID_LEN         = $clog2(MAX_CLAUSE),
  parameter int RSP_DEPTH             = 4,
  parameter int TIMEOUT_CYCLES        = 1024
) (
  input  logic                               clk_i,
  input  logic                               rst_i,
  input  logic                               cmd_valid_i,
  output logic                               cmd_ready_o,
  input  logic [1:0]                         cmd_op_i,
  input  logic [CLAUSE_ID_LEN-1:0]           cmd_clause_id_i,
  input  logic [3*VARIABLE_ENCODING_LEN-1:0] cmd_var_ids_i,
  input  logic [2:0]                         cmd_var_pols_i,
  output logic [31:0]                        core_reg0_o,
  output logic [31:0]                        core_reg1_o,
  output logic [31:0]                        core_reg2_o,
  output logic [31:0]                        core_reg3_o,
  input  logic                               core_clear_req_i,
  input  logic                               core_status_wr_i,
  input  logic [31:0]                        core_status_i,
  input  logic [VARIABLE_ENCODING_LEN:0]     core_impl_i,
  output logic                               rsp_valid_o,
  input  logic                               rsp_ready_i,
  output logic [2:0]                         rsp_code_o,
  output logic [VARIABLE_ENCODING_LEN:0]     rsp_impl_o,
  output logic                               rsp_last_o,
  output logic                               overflow_o,
  output logic                               busy_o
);

  localparam int VW    = VARIABLE_ENCODING_LEN;
  localparam int IW    = VW + 1;
  localparam int PTR_W = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
  localparam int CNT_W = $clog2(RSP_DEPTH + 1);
  localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);

  typedef struct packed {
    logic [2:0]    code;
    logic [IW-1:0] impl;
    logic          last;
  } rsp_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT
  } state_t;

  state_t             state;
  logic [TMR_W-1:0]   timer;
  logic               pending;
  logic               prev_wr;
  logic [31:0]        prev_status;
  logic [IW-1:0]      prev_impl;

  rsp_t               fifo_mem [RSP_DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [CNT_W-1:0]   count;
  logic               overflow;

  logic [31:0]        pack0;
  logic [31:0]        pack1;
  logic [31:0]        pack2;
  logic [31:0]        pack3;
  logic               raw_event;
  logic               event_now;
  logic               is_term;
  logic               is_impl;
  logic               timeout_hit;
  logic               push;
  logic               pop;
  logic               do_write;
  rsp_t               push_data;
  rsp_t               head;

  always_comb begin
    pack0 = '0;
    pack1 = '0;
    pack2 = '0;
    pack3 = '0;
    pack0[1:0] = cmd_op_i;
    if (cmd_op_i == 2'b01) begin
      pack0[2 +: CLAUSE_ID_LEN] = cmd_clause_id_i;
    end
    pack1[0]       = cmd_var_pols_i[0];
    pack1[1 +: VW] = cmd_var_ids_i[0 +: VW];
    pack2[0]       = cmd_var_pols_i[1];
    pack2[1 +: VW] = cmd_var_ids_i[VW +: VW];
    pack3[0]       = cmd_var_pols_i[2];
    pack3[1 +: VW] = cmd_var_ids_i[2*VW +: VW];
  end

  // A status counts once per rising write flag or per change of the written
  // value; an event seen during ISSUE is remembered and served in WAIT.
  always_comb begin
    raw_event   = core_status_wr_i &&
                  (!prev_wr || (core_status_i != prev_status) || (core_impl_i != prev_impl));
    event_now   = (state == S_WAIT) && (raw_event || pending);
    is_term     = (core_status_i == 32'd1) || (core_status_i == 32'd4) ||
                  (core_status_i == 32'd5);
    is_impl     = (core_status_i == 32'd6);
    timeout_hit = (state != S_IDLE) && (timer == TMR_W'(TIMEOUT_CYCLES - 1));
    push        = 1'b0;
    push_data   = '0;
    if (event_now && is_term) begin
      push           = 1'b1;
      push_data.code = core_status_i[2:0];
      push_data.last = 1'b1;
    end else if (timeout_hit) begin
      push           = 1'b1;
      push_data.code = 3'd7;
      push_data.last = 1'b1;
    end else if (event_now && is_impl) begin
      push           = 1'b1;
      push_data.code = 3'd6;
      push_data.impl = core_impl_i;
    end
  end

  assign head        = fifo_mem[rd_ptr];
  assign rsp_valid_o = (count != '0);
  assign rsp_code_o  = rsp_valid_o ? head.code : 3'd0;
  assign rsp_impl_o  = rsp_valid_o ? head.impl : '0;
  assign rsp_last_o  = rsp_valid_o ? head.last : 1'b0;
  assign overflow_o  = overflow;
  assign pop         = rsp_valid_o && rsp_ready_i;
  assign do_write    = push && ((count < CNT_W'(RSP_DEPTH)) || pop);
  // Two free slots guarantee room for at least one implication plus the terminal.
  assign cmd_ready_o = (state == S_IDLE) && (count <= CNT_W'(RSP_DEPTH - 2));

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state       <= S_IDLE;
      core_reg0_o <= '0;
      core_reg1_o <= '0;
      core_reg2_o <= '0;
      core_reg3_o <= '0;
      busy_o      <= 1'b0;
      timer       <= '0;
      pending     <= 1'b0;
      prev_wr     <= 1'b0;
      prev_status <= '0;
      prev_impl   <= '0;
    end else begin
      prev_wr     <= core_status_wr_i;
      prev_status <= core_status_i;
      prev_impl   <= core_impl_i;
      unique case (state)
        S_IDLE: begin
          if (cmd_valid_i && cmd_ready_o && (cmd_op_i != 2'b00)) begin
            core_reg0_o <= pack0;
            core_reg1_o <= pack1;
            core_reg2_o <= pack2;
            core_reg3_o <= pack3;
            busy_o      <= 1'b1;
            timer       <= '0;
            pending     <= 1'b0;
            state       <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          timer <= timer + TMR_W'(1);
          if (timeout_hit) begin
            core_reg0_o[1:0] <= 2'b00;
            busy_o           <= 1'b0;
            state            <= S_IDLE;
          end else begin
            if (raw_event) begin
              pending <= 1'b1;
            end
            if (core_clear_req_i) begin
              core_reg0_o[1:0] <= 2'b00;
              state            <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          timer   <= timer + TMR_W'(1);
          pending <= 1'b0;
          if ((event_now && is_term) || timeout_hit) begin
            core_reg0_o[1:0] <= 2'b00;
            busy_o           <= 1'b0;
            state            <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push && !do_write) begin
        overflow <= 1'b1;
      end
      if (do_write) begin
        fifo_mem[wr_ptr] <= push_data;
        wr_ptr           <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({do_write, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_bcp_cmd_sequencer.sv
// Self-checking bench for bcp_cmd_sequencer: directed handshakes plus randomized
// commands, with responses compared against a queue-based reference model.
module tb_bcp_cmd_sequencer;

  localparam int RSP_DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [6:0]  cmd_clause_id;
  logic [14:0] cmd_var_ids;
  logic [2:0]  cmd_var_pols;
  logic [31:0] reg0;
  logic [31:0] reg1;
  logic [31:0] reg2;
  logic [31:0] reg3;
  logic        clear_req;
  logic        status_wr;
  logic [31:0] status;
  logic [5:0]  impl;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [2:0]  rsp_code;
  logic [5:0]  rsp_impl;
  logic        rsp_last;
  logic        overflow;
  logic        busy;

  int total = 0;
  int bad = 0;

  // Reference model: expected responses in order, with a capacity-limited fill count.
  logic [9:0] exp_q[$];
  logic [9:0] got_q[$];
  int         model_fill = 0;
  bit         model_ovf = 1'b0;

  bcp_cmd_sequencer dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .cmd_valid_i     (cmd_valid),
    .cmd_ready_o     (cmd_ready),
    .cmd_op_i        (cmd_op),
    .cmd_clause_id_i (cmd_clause_id),
    .cmd_var_ids_i   (cmd_var_ids),
    .cmd_var_pols_i  (cmd_var_pols),
    .core_reg0_o     (reg0),
    .core_reg1_o     (reg1),
    .core_reg2_o     (reg2),
    .core_reg3_o     (reg3),
    .core_clear_req_i(clear_req),
    .core_status_wr_i(status_wr),
    .core_status_i   (status),
    .core_impl_i     (impl),
    .rsp_valid_o     (rsp_valid),
    .rsp_ready_i     (rsp_ready),
    .rsp_code_o      (rsp_code),
    .rsp_impl_o      (rsp_impl),
    .rsp_last_o      (rsp_last),
    .overflow_o      (overflow),
    .busy_o          (busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (!rst && rsp_valid && rsp_ready) begin
      got_q.push_back({rsp_code, rsp_impl, rsp_last});
      model_fill--;
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] pack_cmd(input logic [1:0] op, input logic [6:0] cid);
    return 32'(cid) * 4 + 32'(op);
  endfunction

  function automatic logic [31:0] pack_var(input logic [4:0] id, input logic pol);
    return 32'(id) * 2 + 32'(pol);
  endfunction

  task automatic model_push(input logic [2:0] code, input logic [5:0] im, input logic last);
    if (model_fill >= RSP_DEPTH) begin
      model_ovf = 1'b1;
    end else begin
      exp_q.push_back({code, im, last});
      model_fill++;
    end
  endtask

  task automatic compare_responses(input string tag);
    int n;
    check_output({tag, "_rsp_count"}, got_q.size(), exp_q.size());
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      check_output({tag, "_rsp_entry"}, got_q[i], exp_q[i]);
    end
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic apply_stimulus(input logic [1:0] op, input logic [6:0] cid,
                                input logic [14:0] ids, input logic [2:0] pols, output bit ok);
    ok            = 1'b0;
    cmd_valid     = 1'b1;
    cmd_op        = op;
    cmd_clause_id = cid;
    cmd_var_ids   = ids;
    cmd_var_pols  = pols;
    for (int n = 0; n < 50 && !ok; n++) begin
      @(negedge clk);
      if (cmd_ready) begin
        ok = 1'b1;
        @(posedge clk);
        #1;
      end
    end
    cmd_valid = 1'b0;
    check_output("cmd_accept", ok, 1);
  endtask

  task automatic clear_handshake(input logic [31:0] exp0);
    clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    check_output("reg0_op_cleared", reg0, exp0 & 32'hFFFF_FFFC);
  endtask

  task automatic drive_event(input logic [31:0] st, input logic [5:0] im, input int hold);
    status_wr = 1'b1;
    status    = st;
    impl      = im;
    repeat (hold) tick();
  endtask

  task automatic run_cmd(input logic [1:0] op, input logic [6:0] cid, input logic [14:0] ids,
                         input logic [2:0] pols, input logic [5:0] ims[$], input logic [31:0] term,
                         input bit hold_high, input bit unk, input bit compare_now);
    bit ok;
    logic [31:0] exp0;
    exp0 = pack_cmd(op, cid);
    apply_stimulus(op, cid, ids, pols, ok);
    if (!ok) return;
    if (op == 2'd0) begin
      check_output("illegal_busy", busy, 0);
      check_output("illegal_ready", cmd_ready, 1);
      repeat (3) tick();
      compare_responses("illegal");
      return;
    end
    check_output("reg0_pack", reg0, exp0);
    check_output("reg1_pack", reg1, pack_var(ids[4:0], pols[0]));
    check_output("reg2_pack", reg2, pack_var(ids[9:5], pols[1]));
    check_output("reg3_pack", reg3, pack_var(ids[14:10], pols[2]));
    check_output("busy_rise", busy, 1);
    repeat ($urandom_range(0, 3)) tick();
    check_output("issue_hold", reg0[1:0], op);
    clear_handshake(exp0);
    foreach (ims[i]) begin
      model_push(3'd6, ims[i], 1'b0);
      drive_event(32'd6, ims[i], hold_high ? 2 : 1);
      if (!hold_high) begin
        status_wr = 1'b0;
        tick();
      end
    end
    if (unk) begin
      drive_event(32'd2, 6'h3F, 1);
      if (!hold_high) begin
        status_wr = 1'b0;
        tick();
      end
    end
    model_push(term[2:0], 6'd0, 1'b1);
    drive_event(term, 6'h15, 1);
    check_output("busy_fall", busy, 0);
    status_wr = 1'b0;
    status    = '0;
    impl      = '0;
    repeat (2) tick();
    if (compare_now) begin
      compare_responses("cmd");
      check_output("overflow_flag", overflow, model_ovf);
    end
  endtask

  task automatic run_random_cmd();
    logic [1:0]  op;
    logic [6:0]  cid;
    logic [14:0] ids;
    logic [5:0]  ims[$];
    logic [5:0]  im;
    logic [5:0]  last_im;
    logic [31:0] term;
    int          r;
    r    = $urandom_range(0, 9);
    op   = (r == 0) ? 2'd0 : ((r < 5) ? 2'd1 : ((r < 8) ? 2'd2 : 2'd3));
    cid  = (op == 2'd1) ? 7'($urandom_range(0, 90)) : 7'd0;
    ids  = {5'($urandom_range(0, 20)), 5'($urandom_range(0, 20)), 5'($urandom_range(0, 20))};
    last_im = 6'h3F;
    for (int i = 0; i < $urandom_range(0, 2); i++) begin
      im = 6'($urandom_range(0, 63));
      while (im == last_im) im = 6'($urandom_range(0, 63));
      ims.push_back(im);
      last_im = im;
    end
    r    = $urandom_range(0, 2);
    term = (r == 0) ? 32'd1 : ((r == 1) ? 32'd4 : 32'd5);
    run_cmd(op, cid, ids, 3'($urandom), ims, term, 1'($urandom), 1'($urandom), 1'b1);
  endtask

  initial begin
    bit          ok;
    int          cnt;
    logic [5:0]  ims[$];
    rst           = 1'b1;
    cmd_valid     = 1'b0;
    cmd_op        = '0;
    cmd_clause_id = '0;
    cmd_var_ids   = '0;
    cmd_var_pols  = '0;
    clear_req     = 1'b0;
    status_wr     = 1'b0;
    status        = '0;
    impl          = '0;
    rsp_ready     = 1'b1;
    repeat (3) tick();
    check_output("reset_reg0", reg0, 0);
    check_output("reset_rsp_valid", rsp_valid, 0);
    check_output("reset_busy", busy, 0);
    check_output("reset_overflow", overflow, 0);
    rst = 1'b0;
    tick();
    check_output("idle_ready", cmd_ready, 1);

    $display("[TB] update clause");
    ims.delete();
    run_cmd(2'd1, 7'd5, {5'd3, 5'd2, 5'd1}, 3'b101, ims, 32'd1, 1'b0, 1'b0, 1'b1);
    check_output("update_reg0", reg0, 32'h14);
    check_output("update_reg1", reg1, 32'h3);
    check_output("update_reg2", reg2, 32'h4);
    check_output("update_reg3", reg3, 32'h7);

    $display("[TB] decision with implication chain");
    ims = '{6'h0B, 6'h0C};
    run_cmd(2'd2, 7'd0, {5'd7, 5'd6, 5'd4}, 3'b001, ims, 32'd5, 1'b1, 1'b0, 1'b1);
    check_output("chain_reg1", reg1, 32'h9);

    $display("[TB] conflict");
    ims.delete();
    run_cmd(2'd2, 7'd0, {5'd1, 5'd2, 5'd9}, 3'b000, ims, 32'd4, 1'b0, 1'b0, 1'b1);

    $display("[TB] status present during issue");
    apply_stimulus(2'd3, 7'd0, 15'h1234, 3'b010, ok);
    clear_req = 1'b1;
    status_wr = 1'b1;
    status    = 32'd1;
    model_push(3'd1, 6'd0, 1'b1);
    tick();
    clear_req = 1'b0;
    tick();
    check_output("deferred_busy", busy, 0);
    status_wr = 1'b0;
    repeat (2) tick();
    compare_responses("deferred");

    $display("[TB] illegal op");
    run_cmd(2'd0, 7'd0, 15'h0, 3'b000, ims, 32'd1, 1'b0, 1'b0, 1'b1);

    $display("[TB] randomized commands");
    for (int i = 0; i < 12; i++) run_random_cmd();

    $display("[TB] timeout");
    apply_stimulus(2'd2, 7'd0, {5'd0, 5'd0, 5'd3}, 3'b001, ok);
    cnt = 0;
    clear_req = 1'b1;
    tick();
    cnt++;
    clear_req = 1'b0;
    while (busy && cnt < 1100) begin
      tick();
      cnt++;
    end
    model_push(3'd7, 6'd0, 1'b1);
    check_output("timeout_latency", (cnt >= 1022 && cnt <= 1026), 1);
    check_output("timeout_reg0_op", reg0[1:0], 0);
    repeat (2) tick();
    compare_responses("timeout");

    $display("[TB] backpressure");
    rsp_ready = 1'b0;
    ims = '{6'h03, 6'h05, 6'h07, 6'h09, 6'h0B};
    run_cmd(2'd2, 7'd0, {5'd2, 5'd8, 5'd11}, 3'b110, ims, 32'd5, 1'b0, 1'b0, 1'b0);
    check_output("bp_overflow", overflow, model_ovf);
    check_output("bp_ready_blocked", cmd_ready, 0);
    for (int k = 1; k <= RSP_DEPTH; k++) begin
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
      check_output("bp_ready_drain", cmd_ready, ((RSP_DEPTH - k) <= 2) ? 1 : 0);
    end
    compare_responses("bp");
    check_output("bp_overflow_sticky", overflow, 1);

    $display("[TB] reset during wait");
    apply_stimulus(2'd2, 7'd0, 15'h0421, 3'b011, ok);
    clear_handshake(32'h2);
    drive_event(32'd6, 6'h21, 1);
    tick();
    rst       = 1'b1;
    status_wr = 1'b0;
    tick();
    check_output("rst_reg0", reg0, 0);
    check_output("rst_reg1", reg1, 0);
    check_output("rst_rsp_valid", rsp_valid, 0);
    check_output("rst_busy", busy, 0);
    check_output("rst_overflow", overflow, 0);
    check_output("rst_ready", cmd_ready, 1);
    rst = 1'b0;
    got_q.delete();
    exp_q.delete();
    model_fill = 0;
    model_ovf  = 1'b0;
    rsp_ready  = 1'b1;
    repeat (5) tick();
    check_output("rst_no_stale", got_q.size(), 0);
    run_random_cmd();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
